// File: rtl/alu_sequencer.sv
// alu_sequencer: control sequencer for a Baby-style ALU instruction.
// Ports:
//   i_clk, i_reset        clock, asynchronous active-high reset
//   i_start, i_opcode     request and function bits, captured in IDLE only
//   i_acc_neg             accumulator sign, captured with the opcode
//   o_alu_sub, o_a_sel    ALU operation and A-operand select
//   o_alu_oe_n            ALU bus output enable (active low)
//   o_acc_load, o_ci_load single-cycle register load strobes
//   o_skip, o_done        CMP-taken strobe and completion pulse
//   o_busy, o_stop        activity and halted indicators
module alu_sequencer #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic [2:0] i_opcode,
  input  logic       i_acc_neg,
  output logic       o_alu_sub,
  output logic       o_alu_oe_n,
  output logic [1:0] o_a_sel,
  output logic       o_acc_load,
  output logic       o_ci_load,
  output logic       o_skip,
  output logic       o_done,
  output logic       o_busy,
  output logic       o_stop
);
  typedef enum logic [2:0] {IDLE, SETUP, SETTLE, WRITE, FINISH, HALTED} state_t;
  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);
  state_t     r_state, w_next;
  logic [2:0] r_op;
  logic       r_neg;
  logic [3:0] r_cnt;
  logic       w_oper;
  // LDN, JRP and SUB (10x) go through the ALU; everything else finishes directly
  function automatic logic is_alu(input logic [2:0] op);
    return op == 3'b010 || op == 3'b001 || op[2:1] == 2'b10;
  endfunction
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      r_op  <= 3'b000;
      r_neg <= 1'b0;
      r_cnt <= 4'd0;
    end else begin
      if (r_state == IDLE && i_start) begin
        r_op  <= i_opcode;
        r_neg <= i_acc_neg;
      end
      // loaded while leaving SETUP so SETTLE lasts exactly SETTLE_CYCLES
      r_cnt <= r_state == SETUP ? CNT_INIT :
               (r_state == SETTLE && r_cnt != 4'd0) ? r_cnt - 4'd1 : r_cnt;
    end
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = !i_start ? IDLE : is_alu(i_opcode) ? SETUP : FINISH;
      SETUP:   w_next = SETTLE;
      SETTLE:  w_next = r_cnt == 4'd0 ? WRITE : SETTLE;
      WRITE:   w_next = FINISH;
      FINISH:  w_next = r_op == 3'b111 ? HALTED : IDLE;
      HALTED:  w_next = HALTED;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    w_oper     = r_state inside {SETUP, SETTLE, WRITE};
    o_a_sel    = !w_oper ? 2'b00 : r_op == 3'b010 ? 2'b01 : r_op == 3'b001 ? 2'b10 : 2'b00;
    o_alu_sub  = w_oper && r_op != 3'b001;
    o_alu_oe_n = !(r_state inside {SETTLE, WRITE});
    o_acc_load = r_state == WRITE && r_op != 3'b001;
    o_ci_load  = r_state == WRITE && r_op == 3'b001;
    o_skip     = r_state == FINISH && r_op == 3'b110 && r_neg;
    o_done     = r_state == FINISH;
    o_busy     = !(r_state inside {IDLE, HALTED});
    o_stop     = r_state == HALTED;
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed self-checking bench for alu_sequencer.
module tb_alu_sequencer;
  logic clk = 1'b0, rst, start, neg;
  logic [2:0] opcode;
  logic sub, oe_n, acc, ci, skip, done, busy, stop;
  logic [1:0] asel;
  logic sub1, oe_n1, acc1, ci1, skip1, done1, busy1, stop1;
  logic [1:0] asel1;
  logic [9:0] v, v1;
  int n_chk = 0, n_pass = 0;
  localparam logic [9:0] IDLE_V = 10'b1000000000;
  always #5 clk = ~clk;
  // bit order: oe_n, a_sel[1:0], sub, acc_load, ci_load, skip, done, busy, stop
  assign v  = {oe_n, asel, sub, acc, ci, skip, done, busy, stop};
  assign v1 = {oe_n1, asel1, sub1, acc1, ci1, skip1, done1, busy1, stop1};
  alu_sequencer #(.SETTLE_CYCLES(4)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_opcode(opcode), .i_acc_neg(neg),
    .o_alu_sub(sub), .o_alu_oe_n(oe_n), .o_a_sel(asel), .o_acc_load(acc), .o_ci_load(ci),
    .o_skip(skip), .o_done(done), .o_busy(busy), .o_stop(stop));
  alu_sequencer #(.SETTLE_CYCLES(1)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_opcode(opcode), .i_acc_neg(neg),
    .o_alu_sub(sub1), .o_alu_oe_n(oe_n1), .o_a_sel(asel1), .o_acc_load(acc1), .o_ci_load(ci1),
    .o_skip(skip1), .o_done(done1), .o_busy(busy1), .o_stop(stop1));
  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic run_alu(input string tag, input logic [2:0] op, input logic [1:0] a,
                         input logic s, input logic is_ci);
    logic [9:0] e;
    start = 1'b1;
    opcode = op;
    step();
    start = 1'b0;
    opcode = ~op;
    for (int c = 1; c <= 8; c++) begin
      e = IDLE_V;
      if (c <= 7) e[1] = 1'b1;
      if (c <= 6) e[8:6] = {a, s};
      if (c >= 2 && c <= 6) e[9] = 1'b0;
      if (c == 6) e[5:4] = is_ci ? 2'b01 : 2'b10;
      if (c == 7) e[2] = 1'b1;
      check($sformatf("%s_c%0d", tag, c), v, e);
      if (c == 3) start = 1'b1;
      if (c == 4) start = 1'b0;
      if (c < 8) step();
    end
  endtask
  task automatic run_nonalu(input string tag, input logic [2:0] op, input logic n,
                            input logic s);
    start = 1'b1;
    opcode = op;
    neg = n;
    step();
    start = 1'b0;
    neg = ~n;
    check({tag, "_c1"}, v, {1'b1, 2'b00, 1'b0, 2'b00, s, 1'b1, 1'b1, 1'b0});
    step();
    check({tag, "_c2"}, v, IDLE_V);
  endtask
  initial begin
    rst = 1'b1;
    start = 1'b0;
    opcode = 3'b000;
    neg = 1'b0;
    step();
    step();
    check("reset", v, IDLE_V);
    check("reset1", v1, IDLE_V);
    rst = 1'b0;
    run_alu("ldn", 3'b010, 2'b01, 1'b1, 1'b0);
    run_alu("sub", 3'b101, 2'b00, 1'b1, 1'b0);
    run_alu("sub4", 3'b100, 2'b00, 1'b1, 1'b0);
    run_alu("jrp", 3'b001, 2'b10, 1'b0, 1'b1);
    run_nonalu("cmp_neg", 3'b110, 1'b1, 1'b1);
    run_nonalu("cmp_pos", 3'b110, 1'b0, 1'b0);
    run_nonalu("jmp", 3'b000, 1'b1, 1'b0);
    run_nonalu("sto", 3'b011, 1'b1, 1'b0);
    start = 1'b1;
    opcode = 3'b111;
    step();
    start = 1'b0;
    check("stp_c1", v, 10'b1000000110);
    step();
    check("stp_c2", v, 10'b1000000001);
    for (int i = 0; i < 10; i++) begin
      start = 1'b1;
      opcode = 3'b010;
      step();
      start = 1'b0;
      check($sformatf("halt_a%0d", i), v, 10'b1000000001);
      step();
      check($sformatf("halt_b%0d", i), v, 10'b1000000001);
    end
    rst = 1'b1;
    #1;
    check("halt_rst", v, IDLE_V);
    step();
    rst = 1'b0;
    run_alu("ldn_post_halt", 3'b010, 2'b01, 1'b1, 1'b0);
    start = 1'b1;
    opcode = 3'b101;
    step();
    start = 1'b0;
    step();
    step();
    step();
    check("sub_settle3", v, 10'b0001000010);
    rst = 1'b1;
    #1;
    check("mid_rst", v, IDLE_V);
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("mid_rst_hold%0d", i), v, IDLE_V);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("post_rst%0d", i), v, IDLE_V);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    start = 1'b1;
    opcode = 3'b010;
    step();
    opcode = 3'b001;
    check("s1_c1", v1, 10'b1011000010);
    step();
    check("s1_c2", v1, 10'b0011000010);
    step();
    check("s1_c3", v1, 10'b0011100010);
    step();
    check("s1_c4", v1, 10'b1000000110);
    step();
    check("s1_c5", v1, IDLE_V);
    step();
    check("s1_c6", v1, 10'b1100000010);
    start = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
